// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store request path: access sizes, sequencer
// states and the byte-strobe mask derived from an access size.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Strobes are low-aligned; the memory shifts them into the addressed lanes.
  function automatic logic [3:0] wstrb_from_size(input logic [1:0] size);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001;
      SZ_H:    strb = 4'b0011;
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational alignment / size legality check. Shared with the fetch-side
// checker, so it only looks at the low address bits and the size code.
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  logic [1:0] i_size,
  output logic       o_err,
  output logic [3:0] o_wstrb
);

  always_comb begin
    o_err   = 1'b0;
    o_wstrb = wstrb_from_size(i_size);
    case (i_size)
      SZ_B:    o_err = 1'b0;
      SZ_H:    o_err = i_addr_lo[0];
      SZ_W:    o_err = |i_addr_lo;
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// Load/store sequencer in front of the data memory port: accepts one request,
// holds the memory controls for LAT cycles, then returns data or an error.
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int LAT = 2,
  parameter int CW  = 4
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_read_signed,
  output logic [1:0]  mem_size,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_wen;
  logic          r_signed;
  logic          r_err;
  logic [1:0]    r_size;
  logic [3:0]    r_wstrb;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_err;
  logic          w_cnt_zero;
  logic [3:0]    w_wstrb;

  lsu_align_chk u_align_chk (
    .i_addr_lo (req_addr[1:0]),
    .i_size    (req_size),
    .o_err     (w_err),
    .o_wstrb   (w_wstrb)
  );

  assign req_ready  = (r_state == ST_IDLE) && !reset;
  assign w_accept   = req_valid && req_ready;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = w_err ? ST_RESP : ST_WAIT;
      ST_WAIT: if (w_cnt_zero) w_state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are only required to be stable up to acceptance, so every
  // later use goes through these latched copies.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wen    <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_wstrb  <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
      r_wen    <= req_wen;
      r_signed <= req_signed;
      r_err    <= w_err;
      r_size   <= req_size;
      r_wstrb  <= w_wstrb;
      r_cnt    <= CW'(LAT - 1);
    end else if (r_state == ST_WAIT) begin
      if (w_cnt_zero) r_rdata <= r_wen ? '0 : mem_rdata;
      else            r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Outputs are forced quiet during reset because the state register still
  // holds its old value until the reset edge.
  always_comb begin
    mem_addr        = '0;
    mem_read        = 1'b0;
    mem_read_signed = 1'b0;
    mem_size        = '0;
    mem_write       = 1'b0;
    mem_wdata       = '0;
    mem_wstrb       = '0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_err        = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_WAIT: begin
          mem_addr        = r_addr;
          mem_size        = r_size;
          mem_read_signed = r_signed;
          mem_read        = !r_wen;
          mem_write       = r_wen && w_cnt_zero;
          mem_wdata       = r_wdata;
          mem_wstrb       = (r_wen && w_cnt_zero) ? r_wstrb : 4'b0000;
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = r_rdata;
          resp_err   = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Self-checking bench for lsu_req_ctrl: directed scenarios plus randomized
// requests compared against a transaction-level model of the sequencer.
module tb_lsu_req_ctrl;

  localparam int LAT = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_read_signed;
  logic [1:0]  mem_size;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic [31:0] memData;
  int          cycleCnt;
  int          testsRun;
  int          testsFailed;

  int          obsRead;
  int          obsWrite;
  int          obsRespCyc;
  int          obsAcceptCyc;
  logic [31:0] obsRdata;
  logic [31:0] obsWAddr;
  logic [31:0] obsWData;
  logic [3:0]  obsWStrb;
  logic        obsErr;
  logic        obsSideBad;
  logic        obsBusyBad;
  logic        obsTimeout;

  lsu_req_ctrl #(.LAT(LAT), .CW(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_wen         (req_wen),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_read_signed (mem_read_signed),
    .mem_size        (mem_size),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_rdata       (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Memory returns a word that depends on the address it is given.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return memData ^ {a[15:0], a[31:16]};
  endfunction

  assign mem_rdata = memFn(mem_addr);

  function automatic logic modelIllegal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] modelStrb(input logic [1:0] sz);
    return (sz == 2'd0) ? 4'h1 : (sz == 2'd1) ? 4'h3 : 4'hF;
  endfunction

  // Drives one request, waits for acceptance and for the response handshake,
  // and records what was seen on the memory and response sides.
  task automatic applyStimulus(input logic [31:0] addr, input logic wen, input logic [1:0] sz,
                               input logic sgn, input logic [31:0] wdata);
    int   c;
    logic acc, done, seen;
    obsRead = 0; obsWrite = 0; obsRespCyc = -1; obsAcceptCyc = -1;
    obsRdata = 'x; obsErr = 1'bx; obsWAddr = '0; obsWData = '0; obsWStrb = '0;
    obsSideBad = 1'b0; obsBusyBad = 1'b0; obsTimeout = 1'b0;
    req_addr = addr; req_wen = wen; req_size = sz; req_signed = sgn; req_wdata = wdata;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      obsTimeout = 1'b1;
      return;
    end
    obsAcceptCyc = cycleCnt;
    req_addr = $urandom; req_wen = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_wdata = $urandom;
    c = 1; done = 1'b0; seen = 1'b0;
    while (!done && c <= 40) begin
      if (req_ready) obsBusyBad = 1'b1;
      if (mem_read) begin
        obsRead++;
        if (mem_addr !== addr || mem_size !== sz || mem_read_signed !== sgn) obsSideBad = 1'b1;
      end
      if (mem_write) begin
        obsWrite++;
        obsWAddr = mem_addr; obsWData = mem_wdata; obsWStrb = mem_wstrb;
      end else if (mem_wstrb !== 4'h0) obsSideBad = 1'b1;
      if (resp_valid) begin
        if (mem_read || mem_write || mem_addr !== 32'h0) obsBusyBad = 1'b1;
        if (!seen) begin
          seen = 1'b1; obsRespCyc = c; obsRdata = resp_rdata; obsErr = resp_err;
        end
        if (resp_ready) done = 1'b1;
      end
      @(posedge clock); #1;
      c++;
    end
    obsTimeout = !done;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; resp_ready = 1'b1;
    req_addr = 32'h0; req_wen = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_wdata = '0;
    memData = 32'h1234_5678;
    repeat (2) @(posedge clock);
    #1;
    testsRun++;
    if (req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b want 0", req_ready); end
    testsRun++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_resp: valid %b rdata %h err %b want 0", resp_valid, resp_rdata, resp_err);
    end
    testsRun++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
      testsFailed++; $display("[TB] FAIL reset_mem: read %b write %b addr %h strb %h want 0", mem_read, mem_write, mem_addr, mem_wstrb);
    end
    reset = 1'b0; req_valid = 1'b0;
    #1;
    testsRun++;
    if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_ready: got %b want 1", req_ready); end
    @(posedge clock); #1;
    testsRun++;
    if (resp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL idle_quiet: valid %b read %b ready %b want 0/0/1", resp_valid, mem_read, req_ready);
    end
  endtask

  task automatic test_load_word;
    memData = 32'hDEADBEEF ^ {16'h0004, 16'h8000};
    applyStimulus(32'h8000_0004, 1'b0, 2'd2, 1'b0, $urandom);
    testsRun++;
    if (obsRead !== LAT) begin testsFailed++; $display("[TB] FAIL lw_reads: got %0d want %0d", obsRead, LAT); end
    testsRun++;
    if (obsRespCyc !== LAT + 1) begin testsFailed++; $display("[TB] FAIL lw_latency: got %0d want %0d", obsRespCyc, LAT + 1); end
    testsRun++;
    if (obsRdata !== 32'hDEADBEEF || obsErr !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL lw_resp: rdata %h err %b want deadbeef 0", obsRdata, obsErr);
    end
    testsRun++;
    if (obsWrite !== 0 || obsSideBad || obsBusyBad || obsTimeout) begin
      testsFailed++; $display("[TB] FAIL lw_side: writes %0d side %b busy %b timeout %b want 0", obsWrite, obsSideBad, obsBusyBad, obsTimeout);
    end
  endtask

  task automatic test_store_byte;
    memData = $urandom;
    applyStimulus(32'h8000_0003, 1'b1, 2'd0, 1'b0, 32'h0000_00A5);
    testsRun++;
    if (obsWrite !== 1 || obsRead !== 0) begin
      testsFailed++; $display("[TB] FAIL sb_pulses: writes %0d reads %0d want 1 0", obsWrite, obsRead);
    end
    testsRun++;
    if (obsWStrb !== 4'h1 || obsWData !== 32'h0000_00A5 || obsWAddr !== 32'h8000_0003) begin
      testsFailed++; $display("[TB] FAIL sb_write: strb %h data %h addr %h want 1 000000a5 80000003", obsWStrb, obsWData, obsWAddr);
    end
    testsRun++;
    if (obsRdata !== 32'h0 || obsErr !== 1'b0 || obsRespCyc !== LAT + 1) begin
      testsFailed++; $display("[TB] FAIL sb_resp: rdata %h err %b cyc %0d want 0 0 %0d", obsRdata, obsErr, obsRespCyc, LAT + 1);
    end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h8000_0001; sizes[0] = 2'd1;
    addrs[1] = 32'h8000_0000; sizes[1] = 2'd3;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(addrs[i], 1'b0, sizes[i], 1'b1, $urandom);
      testsRun++;
      if (obsErr !== 1'b1 || obsRdata !== 32'h0) begin
        testsFailed++; $display("[TB] FAIL err%0d_resp: err %b rdata %h want 1 0", i, obsErr, obsRdata);
      end
      testsRun++;
      if (obsRespCyc !== 1 || obsRead !== 0 || obsWrite !== 0) begin
        testsFailed++; $display("[TB] FAIL err%0d_timing: cyc %0d reads %0d writes %0d want 1 0 0", i, obsRespCyc, obsRead, obsWrite);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] addr;
    logic [31:0] expData;
    logic        found;
    addr = {$urandom} & 32'hFFFF_FFFC;
    memData = $urandom;
    expData = memFn(addr);
    req_addr = addr; req_wen = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_wdata = $urandom;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (resp_valid) found = 1'b1;
      else begin @(posedge clock); #1; end
    end
    testsRun++;
    if (!found) begin testsFailed++; $display("[TB] FAIL bp_resp_seen: got no resp_valid want 1"); end
    memData = $urandom;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (resp_valid !== 1'b1 || resp_rdata !== expData || req_ready !== 1'b0 ||
          mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold%0d: valid %b rdata %h ready %b read %b write %b want 1 %h 0 0 0",
                 i, resp_valid, resp_rdata, req_ready, mem_read, mem_write, expData);
      end
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    testsRun++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL bp_release: valid %b ready %b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_wait;
    int writes;
    int resps;
    req_addr = 32'h8000_0010; req_wen = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_wdata = $urandom;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    writes = 0; resps = 0;
    if (mem_write) writes++;
    reset = 1'b1;
    #1;
    testsRun++;
    if (mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
      testsFailed++; $display("[TB] FAIL rst_wait_mem: write %b addr %h strb %h want 0", mem_write, mem_addr, mem_wstrb);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    testsRun++;
    if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_wait_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (mem_write) writes++;
      if (resp_valid) resps++;
      @(posedge clock); #1;
    end
    testsRun++;
    if (writes !== 0 || resps !== 0) begin
      testsFailed++; $display("[TB] FAIL rst_wait_quiet: writes %0d resps %0d want 0 0", writes, resps);
    end
  endtask

  task automatic test_back_to_back;
    int          acc0;
    logic [31:0] a0, a1;
    a0 = {$urandom} & 32'hFFFF_FFFC;
    a1 = {$urandom} & 32'hFFFF_FFFE;
    memData = $urandom;
    applyStimulus(a0, 1'b0, 2'd2, 1'b0, $urandom);
    acc0 = obsAcceptCyc;
    testsRun++;
    if (obsRdata !== memFn(a0) || obsBusyBad) begin
      testsFailed++; $display("[TB] FAIL b2b_first: rdata %h busy %b want %h 0", obsRdata, obsBusyBad, memFn(a0));
    end
    applyStimulus(a1, 1'b0, 2'd1, 1'b1, $urandom);
    testsRun++;
    if (obsAcceptCyc - acc0 !== LAT + 2) begin
      testsFailed++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", obsAcceptCyc - acc0, LAT + 2);
    end
    testsRun++;
    if (obsRdata !== memFn(a1) || obsBusyBad || obsSideBad) begin
      testsFailed++; $display("[TB] FAIL b2b_second: rdata %h busy %b side %b want %h 0 0", obsRdata, obsBusyBad, obsSideBad, memFn(a1));
    end
  endtask

  task automatic test_random;
    logic [31:0] addr, wdata, expRdata;
    logic [1:0]  sz;
    logic        wen, sgn, ill;
    int          expReads, expWrites, expCyc;
    for (int n = 0; n < 24; n++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      sz = 2'($urandom_range(0, 3));
      wen = 1'($urandom); sgn = 1'($urandom); wdata = $urandom;
      memData = $urandom;
      ill = modelIllegal(addr, sz);
      expReads  = (!ill && !wen) ? LAT : 0;
      expWrites = (!ill && wen) ? 1 : 0;
      expCyc    = ill ? 1 : LAT + 1;
      expRdata  = (!ill && !wen) ? memFn(addr) : 32'h0;
      applyStimulus(addr, wen, sz, sgn, wdata);
      testsRun++;
      if (obsErr !== ill || obsRdata !== expRdata || obsRespCyc !== expCyc) begin
        testsFailed++;
        $display("[TB] FAIL rnd%0d_resp: err %b rdata %h cyc %0d want %b %h %0d", n, obsErr, obsRdata, obsRespCyc, ill, expRdata, expCyc);
      end
      testsRun++;
      if (obsRead !== expReads || obsWrite !== expWrites) begin
        testsFailed++; $display("[TB] FAIL rnd%0d_pulses: reads %0d writes %0d want %0d %0d", n, obsRead, obsWrite, expReads, expWrites);
      end
      if (expWrites == 1) begin
        testsRun++;
        if (obsWAddr !== addr || obsWData !== wdata || obsWStrb !== modelStrb(sz)) begin
          testsFailed++;
          $display("[TB] FAIL rnd%0d_store: addr %h data %h strb %h want %h %h %h", n, obsWAddr, obsWData, obsWStrb, addr, wdata, modelStrb(sz));
        end
      end
      testsRun++;
      if (obsSideBad || obsBusyBad || obsTimeout) begin
        testsFailed++; $display("[TB] FAIL rnd%0d_proto: side %b busy %b timeout %b want 0", n, obsSideBad, obsBusyBad, obsTimeout);
      end
    end
  endtask

  initial begin
    cycleCnt = 0; testsRun = 0; testsFailed = 0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
